// File: rtl/corvex_pagefault_checker.sv
// Per-channel page-fault checker for the MMU access path.
// Each channel takes a request (command, virtual address, PTE access tag),
// evaluates permissions against the shared privilege CSRs and answers one
// cycle later through a valid/ready response slot.  The first faulting
// request is captured in a single shared fault latch until software clears it.
//
// Access tag layout (PTE low byte): [0]V [1]R [2]W [3]X [4]U [5]G [6]A [7]D
// Cause codes: 0 none, 1 invalid, 2 S->U page (SUM=0), 3 U->S page,
//              4 accessed clear, 5 dirty clear on store, 6 permission.
module corvex_pagefault_checker #(
    parameter int CHANNELS     = 2,
    parameter int VADDR_W      = 32,
    parameter int HW_AD_UPDATE = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        csr_satp_mode_r,
    input  logic [1:0]                  os_csr_mcurrent_privilege,
    input  logic                        os_csr_mstatus_mprv,
    input  logic                        os_csr_mstatus_mxr,
    input  logic                        os_csr_mstatus_sum,
    input  logic [1:0]                  os_csr_mstatus_mpp,
    input  logic [CHANNELS-1:0]         req_valid,
    output logic [CHANNELS-1:0]         req_ready,
    input  logic [4*CHANNELS-1:0]       req_cmd,
    input  logic [VADDR_W*CHANNELS-1:0] req_vaddr,
    input  logic [8*CHANNELS-1:0]       req_accesstag,
    output logic [CHANNELS-1:0]         resp_valid,
    input  logic [CHANNELS-1:0]         resp_ready,
    output logic [CHANNELS-1:0]         resp_pagefault,
    output logic [CHANNELS-1:0]         resp_ad_update,
    output logic [3*CHANNELS-1:0]       resp_cause,
    output logic                        fault_valid,
    output logic [2:0]                  fault_channel,
    output logic [VADDR_W-1:0]          fault_vaddr,
    output logic [2:0]                  fault_cause,
    input  logic                        fault_clear
);

    // Cache command encodings seen on req_cmd.
    localparam logic [3:0] CACHE_CMD_LOAD    = 4'h0;
    localparam logic [3:0] CACHE_CMD_STORE   = 4'h1;
    localparam logic [3:0] CACHE_CMD_EXECUTE = 4'h2;

    localparam logic [1:0] PRV_U = 2'd0;
    localparam logic [1:0] PRV_S = 2'd1;
    localparam logic [1:0] PRV_M = 2'd3;

    localparam int TAG_V = 0;
    localparam int TAG_R = 1;
    localparam int TAG_W = 2;
    localparam int TAG_X = 3;
    localparam int TAG_U = 4;
    localparam int TAG_A = 6;
    localparam int TAG_D = 7;

    localparam logic [2:0] CAUSE_NONE    = 3'd0;
    localparam logic [2:0] CAUSE_INVALID = 3'd1;
    localparam logic [2:0] CAUSE_SUM     = 3'd2;
    localparam logic [2:0] CAUSE_USER    = 3'd3;
    localparam logic [2:0] CAUSE_ACCESS  = 3'd4;
    localparam logic [2:0] CAUSE_DIRTY   = 3'd5;
    localparam logic [2:0] CAUSE_PERM    = 3'd6;

    localparam logic HW_AD = (HW_AD_UPDATE != 0);

    // Read/write/execute permission check for the decoded command.
    // Commands other than load/store/execute never raise a permission fault.
    function automatic logic perm_violation(input logic [7:0] tag,
                                            input logic [3:0] cmd,
                                            input logic       mxr);
        logic viol;
        viol = 1'b0;
        case (cmd)
            CACHE_CMD_STORE:   viol = !tag[TAG_W];
            CACHE_CMD_LOAD:    viol = !tag[TAG_R] && !(mxr && tag[TAG_X]);
            CACHE_CMD_EXECUTE: viol = !tag[TAG_X];
            default:           viol = 1'b0;
        endcase
        perm_violation = viol;
    endfunction

    // Highest-priority fault cause for one request with translation active.
    function automatic logic [2:0] cause_of(input logic [7:0] tag,
                                            input logic [3:0] cmd,
                                            input logic [1:0] prv,
                                            input logic       sum,
                                            input logic       mxr);
        logic [2:0] c;
        if (!tag[TAG_V] || (!tag[TAG_R] && !tag[TAG_X])) begin
            c = CAUSE_INVALID;
        end else if ((prv == PRV_S) && tag[TAG_U] && !sum) begin
            c = CAUSE_SUM;
        end else if ((prv == PRV_U) && !tag[TAG_U]) begin
            c = CAUSE_USER;
        end else if (!tag[TAG_A]) begin
            c = CAUSE_ACCESS;
        end else if ((cmd == CACHE_CMD_STORE) && !tag[TAG_D]) begin
            c = CAUSE_DIRTY;
        end else if (perm_violation(tag, cmd, mxr)) begin
            c = CAUSE_PERM;
        end else begin
            c = CAUSE_NONE;
        end
        cause_of = c;
    endfunction

    logic [1:0]          eff_prv;
    logic                xlate_on;
    logic [CHANNELS-1:0] accept;

    logic [CHANNELS-1:0]   chk_pf;
    logic [CHANNELS-1:0]   chk_ad;
    logic [3*CHANNELS-1:0] chk_cause;

    logic [CHANNELS-1:0]   resp_valid_q, resp_valid_d;
    logic [CHANNELS-1:0]   resp_pf_q,    resp_pf_d;
    logic [CHANNELS-1:0]   resp_ad_q,    resp_ad_d;
    logic [3*CHANNELS-1:0] resp_cause_q, resp_cause_d;

    logic                  fault_valid_q,   fault_valid_d;
    logic [2:0]            fault_channel_q, fault_channel_d;
    logic [VADDR_W-1:0]    fault_vaddr_q,   fault_vaddr_d;
    logic [2:0]            fault_cause_q,   fault_cause_d;

    logic [CHANNELS-1:0]   fault_hit;
    logic                  any_hit;
    logic [2:0]            sel_chan;
    logic [VADDR_W-1:0]    sel_vaddr;
    logic [2:0]            sel_cause;

    // MPRV makes loads/stores run with the previous privilege; machine mode
    // or bare translation bypasses all checks.
    assign eff_prv  = os_csr_mstatus_mprv ? os_csr_mstatus_mpp : os_csr_mcurrent_privilege;
    assign xlate_on = csr_satp_mode_r && (eff_prv != PRV_M);

    assign req_ready = ~resp_valid_q | resp_ready;
    assign accept    = req_valid & req_ready;

    // Evaluate each channel's request against the CSRs of this cycle.
    always_comb begin
        logic [2:0] c;
        logic [7:0] tag;
        logic [3:0] cmd;
        logic       ad;
        chk_pf    = '0;
        chk_ad    = '0;
        chk_cause = '0;
        c   = CAUSE_NONE;
        tag = '0;
        cmd = '0;
        ad  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            tag = req_accesstag[i*8 +: 8];
            cmd = req_cmd[i*4 +: 4];
            c   = CAUSE_NONE;
            ad  = 1'b0;
            if (xlate_on) begin
                c = cause_of(tag, cmd, eff_prv, os_csr_mstatus_sum, os_csr_mstatus_mxr);
                // A/D-only faults become a hardware update request, unless a
                // permission fault is hiding behind them.
                ad = HW_AD && ((c == CAUSE_ACCESS) || (c == CAUSE_DIRTY)) &&
                     !perm_violation(tag, cmd, os_csr_mstatus_mxr);
            end
            chk_cause[i*3 +: 3] = c;
            chk_ad[i]           = ad;
            chk_pf[i]           = (c != CAUSE_NONE) && !ad;
        end
    end

    // Response slot: load on acceptance, hold until the consumer takes it.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_pf_d    = resp_pf_q;
        resp_ad_d    = resp_ad_q;
        resp_cause_d = resp_cause_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (accept[i]) begin
                resp_valid_d[i]        = 1'b1;
                resp_pf_d[i]           = chk_pf[i];
                resp_ad_d[i]           = chk_ad[i];
                resp_cause_d[i*3 +: 3] = chk_cause[i*3 +: 3];
            end else if (resp_ready[i]) begin
                resp_valid_d[i] = 1'b0;
            end
        end
    end

    // Pick the lowest-index channel whose accepted request faults.
    always_comb begin
        fault_hit = accept & chk_pf;
        any_hit   = |fault_hit;
        sel_chan  = '0;
        sel_vaddr = '0;
        sel_cause = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (fault_hit[i]) begin
                sel_chan  = 3'(i);
                sel_vaddr = req_vaddr[i*VADDR_W +: VADDR_W];
                sel_cause = chk_cause[i*3 +: 3];
            end
        end
    end

    // Fault latch: capture only when empty or being cleared this cycle.
    always_comb begin
        fault_valid_d   = fault_valid_q;
        fault_channel_d = fault_channel_q;
        fault_vaddr_d   = fault_vaddr_q;
        fault_cause_d   = fault_cause_q;
        if (any_hit && (!fault_valid_q || fault_clear)) begin
            fault_valid_d   = 1'b1;
            fault_channel_d = sel_chan;
            fault_vaddr_d   = sel_vaddr;
            fault_cause_d   = sel_cause;
        end else if (fault_clear) begin
            fault_valid_d = 1'b0;
        end
    end

    // State registers; reset discards in-flight responses and the latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q    <= '0;
            resp_pf_q       <= '0;
            resp_ad_q       <= '0;
            resp_cause_q    <= '0;
            fault_valid_q   <= 1'b0;
            fault_channel_q <= '0;
            fault_vaddr_q   <= '0;
            fault_cause_q   <= '0;
        end else begin
            resp_valid_q    <= resp_valid_d;
            resp_pf_q       <= resp_pf_d;
            resp_ad_q       <= resp_ad_d;
            resp_cause_q    <= resp_cause_d;
            fault_valid_q   <= fault_valid_d;
            fault_channel_q <= fault_channel_d;
            fault_vaddr_q   <= fault_vaddr_d;
            fault_cause_q   <= fault_cause_d;
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_pagefault = resp_pf_q;
    assign resp_ad_update = resp_ad_q;
    assign resp_cause     = resp_cause_q;
    assign fault_valid    = fault_valid_q;
    assign fault_channel  = fault_channel_q;
    assign fault_vaddr    = fault_vaddr_q;
    assign fault_cause    = fault_cause_q;

endmodule
